// File: rtl/multivar_wait_seq.sv
`default_nettype none
// ============================================================================
// multivar_wait_seq : in-order hardware wait sequencer over NUM_VARS variables
// Optional per-step timeout when MULTIVAR_WAIT_TIMEOUT_EN is defined. Rev 1.0
// ============================================================================

module multivar_wait_seq #(
   parameter int WIDTH     = 32,
   parameter int NUM_VARS  = 3,
   parameter int NUM_STEPS = 4,
   parameter int SIGNED    = 1,
   parameter int TMO_W     = 16,
   localparam int IW  = $clog2(NUM_VARS),
   localparam int SIW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
   localparam int TW  = 3 + 1 + 3*IW,
   localparam int SW  = 2*TW + 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_VARS*WIDTH-1:0] vars,
   input  logic                      prog_we,
   input  logic [SIW-1:0]            prog_addr,
   input  logic [SW-1:0]             prog_data,
   input  logic                      start,
   input  logic                      abort,
   input  logic [TMO_W-1:0]          tmo_limit,
   output logic                      busy,
   output logic                      step_done,
   output logic [SIW-1:0]            step_idx,
   output logic                      done,
   output logic                      timeout
);

   localparam int NV = 1 << IW;
   // Flipping the top bit turns a signed compare into an unsigned one.
   localparam logic [WIDTH:0] BIAS = (SIGNED != 0) ? {1'b1, {WIDTH{1'b0}}} : '0;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t           state, state_n;
   logic [SIW-1:0]   cur_step, cur_step_n;
   logic [SIW-1:0]   step_idx_n;
   logic             step_done_n, done_n;
   logic [SW-1:0]    prog_mem [NUM_STEPS];
   logic [SW-1:0]    step_word;
   logic [WIDTH-1:0] v [NV];
   logic [1:0]       term_hit;
   logic [1:0]       comb_sel;
   logic             last_flag, last_step, cond;

   function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
      return (SIGNED != 0) ? {x[WIDTH-1], x} : {1'b0, x};
   endfunction

   // Index slots beyond NUM_VARS read as zero.
   generate
      for (genvar n = 0; n < NV; n++) begin : g_vars
         if (n < NUM_VARS) begin : g_live
            assign v[n] = vars[n*WIDTH +: WIDTH];
         end else begin : g_zero
            assign v[n] = '0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (prog_we && (state == IDLE) && (int'(prog_addr) < NUM_STEPS))
         prog_mem[prog_addr] <= prog_data;
   end

   assign step_word = prog_mem[cur_step];
   assign comb_sel  = step_word[2*TW +: 2];
   assign last_flag = step_word[2*TW+2];
   assign last_step = last_flag || (cur_step == SIW'(NUM_STEPS-1));

   generate
      for (genvar t = 0; t < 2; t++) begin : g_term
         logic [TW-1:0]    tw;
         logic [IW-1:0]    li, l2i, ri;
         logic [WIDTH:0]   lhs, rhs;
         logic             hit;
         assign tw  = step_word[t*TW +: TW];
         assign li  = tw[4 +: IW];
         assign l2i = tw[4+IW +: IW];
         assign ri  = tw[4+2*IW +: IW];
         assign lhs = (ext(v[li]) + (tw[3] ? ext(v[l2i]) : '0)) ^ BIAS;
         assign rhs = ext(v[ri]) ^ BIAS;
         always_comb begin
            hit = 1'b0;
            case (tw[2:0])
               3'd0:    hit = (lhs >  rhs);
               3'd1:    hit = (lhs <  rhs);
               3'd2:    hit = (lhs == rhs);
               3'd3:    hit = (lhs != rhs);
               3'd4:    hit = (lhs >= rhs);
               3'd5:    hit = (lhs <= rhs);
               default: hit = 1'b0;
            endcase
         end
         assign term_hit[t] = hit;
      end
   endgenerate

   always_comb begin
      cond = term_hit[0];
      case (comb_sel)
         2'd1:    cond = term_hit[0] & term_hit[1];
         2'd2:    cond = term_hit[0] | term_hit[1];
         default: cond = term_hit[0];
      endcase
   end

`ifdef MULTIVAR_WAIT_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
   logic             timeout_n;
`else
   logic unused_tmo;
   assign unused_tmo = ^tmo_limit;
   assign timeout    = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      cur_step_n  = cur_step;
      step_done_n = 1'b0;
      done_n      = 1'b0;
      step_idx_n  = step_idx;
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
      tmo_cnt_n   = tmo_cnt;
      timeout_n   = timeout;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               state_n    = WAIT;
               cur_step_n = '0;
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
               tmo_cnt_n  = '0;
               timeout_n  = 1'b0;
`endif
            end
         end
         WAIT: begin
            if (abort) begin
               state_n = IDLE;
            end else if (cond) begin
               step_done_n = 1'b1;
               step_idx_n  = cur_step;
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
               tmo_cnt_n   = '0;
`endif
               if (last_step) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  cur_step_n = cur_step + 1'b1;
               end
            end
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
            // This false cycle is the tmo_limit-th one spent in the step.
            else if ((tmo_limit != '0) && ((tmo_cnt + 1'b1) == tmo_limit)) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               tmo_cnt_n = tmo_cnt + 1'b1;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_step  <= '0;
         step_done <= 1'b0;
         step_idx  <= '0;
         done      <= 1'b0;
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
         tmo_cnt   <= '0;
         timeout   <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         cur_step  <= cur_step_n;
         step_done <= step_done_n;
         step_idx  <= step_idx_n;
         done      <= done_n;
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_n;
         timeout   <= timeout_n;
`endif
      end
   end

   assign busy = (state == WAIT);

endmodule

`default_nettype wire

// File: tb/tb_multivar_wait_seq.sv
`default_nettype none
// Directed self-checking bench for multivar_wait_seq (signed and unsigned instances).

module tb_multivar_wait_seq;

   logic        clk = 1'b0;
   logic        rst, prog_we, start, abort;
   logic [1:0]  prog_addr;
   logic [22:0] prog_data;
   logic [15:0] tmo_limit;
   logic [31:0] a, b, c;
   logic [95:0] vars;
   logic        busy, step_done, done, timeout;
   logic [1:0]  step_idx;
   logic        busy_u, step_done_u, done_u, timeout_u;
   logic [1:0]  step_idx_u;
   int          total = 0;
   int          bad = 0;

   assign vars = {c, b, a};
   always #5 clk = ~clk;

   multivar_wait_seq #(.SIGNED(1)) dut (
      .clk(clk), .rst(rst), .vars(vars), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .abort(abort), .tmo_limit(tmo_limit),
      .busy(busy), .step_done(step_done), .step_idx(step_idx), .done(done), .timeout(timeout)
   );

   multivar_wait_seq #(.SIGNED(0)) dut_u (
      .clk(clk), .rst(rst), .vars(vars), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .abort(abort), .tmo_limit(tmo_limit),
      .busy(busy_u), .step_done(step_done_u), .step_idx(step_idx_u), .done(done_u),
      .timeout(timeout_u)
   );

   function automatic logic [9:0] mk_term(input int op, input int en, input int li,
                                          input int l2i, input int ri);
      return {2'(ri), 2'(l2i), 2'(li), 1'(en), 3'(op)};
   endfunction

   function automatic logic [22:0] mk_step(input logic [9:0] t0, input logic [9:0] t1,
                                           input int comb, input int last);
      return {1'(last), 2'(comb), t1, t0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_slot(input int addr, input logic [22:0] w);
      prog_we   = 1'b1;
      prog_addr = 2'(addr);
      prog_data = w;
      tick();
      prog_we   = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL reset_step_done got=%0b want=0", step_done); end
      total++; if (step_idx !== 2'd0) begin bad++; $display("FAIL reset_step_idx got=%0d want=0", step_idx); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", timeout); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_three_step();
      int exp_cnt [6]  = '{0, 0, 1, 0, 1, 1};
      int exp_idx [6]  = '{0, 0, 0, 0, 1, 2};
      int exp_done [6] = '{0, 0, 0, 0, 0, 1};
      a = 0; b = 0; c = 0;
      write_slot(0, mk_step(mk_term(0, 0, 0, 0, 1), 10'd0, 0, 0));
      write_slot(1, mk_step(mk_term(1, 1, 0, 1, 2), 10'd0, 0, 0));
      write_slot(2, mk_step(mk_term(1, 0, 0, 0, 1), mk_term(0, 0, 1, 0, 2), 1, 1));
      do_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL three_busy_start got=%0b want=1", busy); end
      for (int ph = 0; ph < 6; ph++) begin
         int cnt = 0;
         int dcnt = 0;
         int idx = -1;
         case (ph)
            1: b = 1;
            2: a = 2;
            3: c = 3;
            4: c = 4;
            5: b = 5;
            default: ;
         endcase
         for (int k = 0; k < 4; k++) begin
            // start while busy must be ignored
            if (ph == 3 && k == 0) start = 1'b1;
            tick();
            start = 1'b0;
            if (step_done === 1'b1) begin cnt++; idx = int'(step_idx); end
            if (done === 1'b1) dcnt++;
         end
         total++; if (cnt != exp_cnt[ph]) begin bad++; $display("FAIL three_pulses ph=%0d got=%0d want=%0d", ph, cnt, exp_cnt[ph]); end
         if (exp_cnt[ph] > 0) begin
            total++; if (idx != exp_idx[ph]) begin bad++; $display("FAIL three_idx ph=%0d got=%0d want=%0d", ph, idx, exp_idx[ph]); end
         end
         total++; if (dcnt != exp_done[ph]) begin bad++; $display("FAIL three_done ph=%0d got=%0d want=%0d", ph, dcnt, exp_done[ph]); end
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL three_busy_end got=%0b want=0", busy); end
   endtask

   task automatic test_immediate();
      a = 5; b = 1; c = 0;
      write_slot(0, mk_step(mk_term(0, 0, 0, 0, 1), 10'd0, 0, 1));
      start = 1'b1;
      tick();
      start = 1'b0;
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL imm_edge1_step_done got=%0b want=0", step_done); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL imm_edge1_busy got=%0b want=1", busy); end
      tick();
      total++; if (step_done !== 1'b1) begin bad++; $display("FAIL imm_edge2_step_done got=%0b want=1", step_done); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL imm_edge2_done got=%0b want=1", done); end
      total++; if (step_idx !== 2'd0) begin bad++; $display("FAIL imm_edge2_idx got=%0d want=0", step_idx); end
      tick();
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL imm_edge3_step_done got=%0b want=0", step_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL imm_edge3_busy got=%0b want=0", busy); end
   endtask

   task automatic test_signed();
      a = 32'hFFFF_FFFF; b = 1; c = 0;
      write_slot(0, mk_step(mk_term(1, 0, 0, 0, 1), 10'd0, 0, 1));
      do_start();
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL signed_lt_done got=%0b want=1", done); end
      tick(); tick(); tick();
      total++; if (busy_u !== 1'b1) begin bad++; $display("FAIL unsigned_lt_busy got=%0b want=1", busy_u); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (busy_u !== 1'b0) begin bad++; $display("FAIL unsigned_abort_busy got=%0b want=0", busy_u); end
   endtask

   task automatic test_sum();
      a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; c = 0;
      write_slot(0, mk_step(mk_term(0, 1, 0, 1, 2), 10'd0, 0, 1));
      do_start();
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL sum_gt_done got=%0b want=1", done); end
      write_slot(0, mk_step(mk_term(1, 1, 0, 1, 2), 10'd0, 0, 1));
      do_start();
      tick(); tick(); tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL sum_lt_busy got=%0b want=1", busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      int cnt = 0;
      a = 0; b = 0; c = 0;
      write_slot(0, mk_step(mk_term(0, 0, 0, 0, 1), 10'd0, 0, 1));
      do_start();
      tick(); tick();
      a = 5;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL abort_step_done got=%0b want=0", step_done); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b want=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
      tick();
      total++; if (step_done !== 1'b0) begin bad++; $display("FAIL abort_late_pulse got=%0b want=0", step_done); end
      a = 0;
      // write attempted while busy must not alter the program
      do_start();
      write_slot(0, mk_step(mk_term(2, 0, 0, 0, 1), 10'd0, 0, 1));
      tick();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_write_busy got=%0b want=1", busy); end
      abort = 1'b1; tick(); abort = 1'b0;
      do_start();
      for (int k = 0; k < 3; k++) begin
         tick();
         if (step_done === 1'b1) cnt++;
      end
      total++; if (cnt != 0) begin bad++; $display("FAIL busy_write_ignored pulses got=%0d want=0", cnt); end
      abort = 1'b1; tick(); abort = 1'b0;
      write_slot(0, mk_step(mk_term(2, 0, 0, 0, 1), 10'd0, 0, 1));
      do_start();
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL idle_write_done got=%0b want=1", done); end
   endtask

   task automatic test_midrun_reset();
      a = 0; b = 1; c = 0;
      do_start();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
      b = 0;
      do_start();
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL midrst_ram_kept done got=%0b want=1", done); end
   endtask

`ifdef MULTIVAR_WAIT_TIMEOUT_EN
   task automatic test_timeout();
      a = 0; b = 0; c = 0;
      tmo_limit = 16'd10;
      write_slot(0, mk_step(mk_term(0, 0, 0, 0, 1), 10'd0, 0, 1));
      do_start();
      repeat (9) tick();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_early got=%0b want=0", timeout); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_early_busy got=%0b want=1", busy); end
      tick();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_raised got=%0b want=1", timeout); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL tmo_done got=%0b want=0", done); end
      do_start();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_cleared got=%0b want=0", timeout); end
      repeat (9) tick();
      a = 5;
      tick();
      total++; if (done !== 1'b1) begin bad++; $display("FAIL tmo_limit_win_done got=%0b want=1", done); end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_limit_win_tmo got=%0b want=0", timeout); end
      tmo_limit = 16'd0;
   endtask
`endif

   initial begin
      rst = 1'b1; prog_we = 1'b0; start = 1'b0; abort = 1'b0;
      prog_addr = '0; prog_data = '0; tmo_limit = '0;
      a = 0; b = 0; c = 0;
      test_reset();
      test_three_step();
      test_immediate();
      test_signed();
      test_sum();
      test_abort();
      test_midrun_reset();
`ifdef MULTIVAR_WAIT_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multivar_wait_seq.md
Name: multivar_wait_seq

Overview:
- Synthesizable, parametrised successor to the behavioural multi-variable wait check.
- Holds a small program of wait steps. Each step is one or two compare terms over NUM_VARS monitored variables, where a term has the form (v[i] [+ v[j]]) OP v[k].
- Steps are executed strictly in order; the block advances when the current step's condition holds.
- Sits beside the scheduler test logic as a hardware event sequencer, pulsing per-step and completion flags.

Parameters:
- WIDTH, 32, bit width of each monitored variable.
- NUM_VARS, 3, number of monitored variables (>=2).
- NUM_STEPS, 4, program depth (>=1).
- SIGNED, 1, 1 = two's-complement compares; 0 = unsigned.
- TMO_W, 16, width of the per-step timeout counter (used only with the optional feature).
- Derived: IW=$clog2(NUM_VARS), SIW=$clog2(NUM_STEPS), TW=3+1+3*IW, SW=2*TW+3.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vars  in  NUM_VARS*WIDTH  packed variables; v[n]=vars[n*WIDTH +: WIDTH].
- prog_we  in  1  program write strobe.
- prog_addr  in  SIW  step slot written.
- prog_data  in  SW  step word.
- start  in  1  begin execution at step 0.
- abort  in  1  cancel execution.
- tmo_limit  in  TMO_W  per-step cycle limit (optional feature only).
- busy  out  1  sequencer in WAIT.
- step_done  out  1  one-cycle pulse: a step was satisfied.
- step_idx  out  SIW  index of the step that completed (valid with step_done).
- done  out  1  one-cycle pulse: last step satisfied.
- timeout  out  1  sticky error flag (optional feature only).

Behaviour:
- Reset: state=IDLE, cur_step=0; busy, step_done, step_idx, done, timeout all 0. The program RAM is not cleared.
- Term layout, LSB first: op[2:0], lhs2_en, lhs_idx, lhs2_idx, rhs_idx.
- op encoding: 0 GT, 1 LT, 2 EQ, 3 NE, 4 GE, 5 LE; 6 and 7 evaluate false.
- Step word, LSB first: term0[TW], term1[TW], comb[1:0], last.
- comb encoding: 0 = term0 only, 1 = term0 AND term1, 2 = term0 OR term1, 3 = term0 only.
- Arithmetic:
  - Operands are extended to WIDTH+1 bits: sign-extended if SIGNED, else zero-extended.
  - lhs = v[lhs_idx] + (lhs2_en ? v[lhs2_idx] : 0), computed at WIDTH+1 bits, so no overflow.
  - rhs = v[rhs_idx], extended the same way.
  - Any index >= NUM_VARS reads 0.
- Program write: prog_we writes the slot at the next edge. It is honoured in IDLE only and ignored while busy.
- IDLE:
  - start=1 -> WAIT, cur_step=0, busy=1 next cycle.
  - If prog_we and start are asserted in the same cycle, the write lands first and the step is used.
- WAIT:
  - Each cycle, combinationally evaluate the condition of step cur_step against the current vars.
  - If true: next cycle step_done=1 and step_idx=cur_step.
    - last=1 or cur_step==NUM_STEPS-1 -> done=1, busy=0, state=IDLE.
    - Otherwise cur_step++ and evaluation of the new step starts that same cycle.
  - At most one step completes per cycle. A condition already true on entry completes in 1 cycle.
  - Total latency from start to step 0's step_done is 2 edges.
- abort in WAIT: next cycle state=IDLE, busy=0. No step_done or done pulse, even if the condition is true in the same cycle; abort wins.
- start while busy: ignored.
- rst mid-run: forces the reset values at the next edge; the program RAM is retained.
- Variables are sampled level-sensitively. A condition that is true for a single cycle is caught.

Optional Feature:
- Macro: MULTIVAR_WAIT_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter clears on each step entry and increments each WAIT cycle while the condition is false.
  - When the counter reaches tmo_limit with the condition still false: timeout=1 (sticky), state=IDLE, busy=0, no done.
  - A true condition in the limit cycle wins; no timeout is raised.
  - tmo_limit=0 disables the timeout.
  - timeout clears on rst or on an accepted start.
- Undefined: no counter logic; timeout is tied to 0; tmo_limit is unused; WAIT can last forever.

Test Plan:
- Three-step program, SIGNED=1:
  - Program: step0 = v0 GT v1; step1 = (v0+v1) LT v2; step2 = v0 LT v1 AND v1 GT v2, last=1.
  - Drive a,b,c = (0,0,0), then b=1, a=2, c=3, c=4, b=5, spaced 4 cycles apart.
  - Required: step_done for idx 0 after a=2, idx 1 after c=4, idx 2 with done after b=5; no other pulses.
- Immediate pass: v0=5, v1=1, one-step program GT, start -> step_done and done exactly 2 edges after start.
- Signed vs unsigned: v0=32'hFFFF_FFFF, v1=1, op LT.
  - SIGNED=1: completes.
  - SIGNED=0: stays busy.
- Sum without overflow: v0=v1=32'h7FFF_FFFF (SIGNED=1), v2=0, (v0+v1) GT v2 -> completes; no wrap to negative.
- Abort and restart:
  - abort in the same cycle the condition turns true -> no step_done, busy=0.
  - prog_we while busy is ignored, verified by readback behaviour on the next start.
- MULTIVAR_WAIT_TIMEOUT_EN, tmo_limit=10, condition never true:
  - timeout=1 after 10 WAIT cycles, busy=0.
  - start clears timeout.
  - With the condition true on cycle 10, done and no timeout.
